alu_seq: RTL and testbench

- Sequential ALU stage directly upstream of the accumulator.
- Consumes the accumulator value as operand A and a second operand B.
- Computes one of eight operations and produces a registered result plus a one-cycle `done` pulse, which the integrator wires to the accumulator's write-enable.
- Single-cycle ops finish in one clock; multiply is an iterative shift-add taking SIZE clocks.

---
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU feeding the accumulator: single-cycle logic/arith ops plus an
// iterative shift-add multiply; done pulses once per accepted start.
module alu_seq #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [SIZE-1:0] a_val,
  input  logic [SIZE-1:0] b_val,
  output logic [SIZE-1:0] result,
  output logic            carry,
  output logic            zero,
  output logic            busy,
  output logic            done
);

  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(SIZE - 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  state_e state_q, state_d;

  // Multiply working registers; A is 2*SIZE wide so its shifted-out bits
  // still reach the upper half of the product for overflow detection.
  logic [2*SIZE-1:0] a_q;
  logic [SIZE-1:0]   b_q;
  logic [2*SIZE-1:0] prod_q;
  logic [CW-1:0]     cnt_q;

  logic [2*SIZE-1:0] mul_addend;
  logic [2*SIZE-1:0] prod_step;

  logic [SIZE:0]     sum_ext;
  logic [SIZE:0]     diff_ext;
  logic [SIZE-1:0]   alu_res;
  logic              alu_carry;

  logic              load_res;
  logic              mul_load;
  logic              mul_step;
  logic [SIZE-1:0]   res_d;
  logic              carry_d;

  assign sum_ext    = {1'b0, a_val} + {1'b0, b_val};
  assign diff_ext   = {1'b0, a_val} - {1'b0, b_val};
  assign mul_addend = b_q[0] ? a_q : '0;
  assign prod_step  = prod_q + mul_addend;
  assign busy       = (state_q == MUL);

  // NOTE: every variable written in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        alu_res   = sum_ext[SIZE-1:0];
        alu_carry = sum_ext[SIZE];
      end
      OP_SUB: begin
        alu_res   = diff_ext[SIZE-1:0];
        alu_carry = diff_ext[SIZE];
      end
      OP_AND: alu_res = a_val & b_val;
      OP_OR:  alu_res = a_val | b_val;
      OP_XOR: alu_res = a_val ^ b_val;
      OP_SHL: begin
        alu_res   = {a_val[SIZE-2:0], 1'b0};
        alu_carry = a_val[SIZE-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, a_val[SIZE-1:1]};
        alu_carry = a_val[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    res_d    = alu_res;
    carry_d  = alu_carry;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op_e'(op) == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = MUL;
          end else begin
            load_res = 1'b1;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (cnt_q == LAST_ITER) begin
          load_res = 1'b1;
          res_d    = prod_step[SIZE-1:0];
          carry_d  = |prod_step[2*SIZE-1:SIZE];
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= load_res;
      if (load_res) begin
        result <= res_d;
        carry  <= carry_d;
        // zero follows the value being registered into result, not any
        // partial product seen during iteration.
        zero   <= (res_d == '0);
      end
      if (mul_load) begin
        a_q    <= {{SIZE{1'b0}}, a_val};
        b_q    <= b_val;
        prod_q <= '0;
        cnt_q  <= '0;
      end else if (mul_step) begin
        prod_q <= prod_step;
        a_q    <= a_q << 1;
        b_q    <= b_q >> 1;
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (SIZE=8): single-cycle ops,
// multiply latency/overflow, operand isolation, back-to-back and reset abort.
module tb_alu_seq;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [2:0]      op;
  logic [SIZE-1:0] a_val;
  logic [SIZE-1:0] b_val;
  logic [SIZE-1:0] result;
  logic            carry;
  logic            zero;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;

  alu_seq #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .op    (op),
    .a_val (a_val),
    .b_val (b_val),
    .result(result),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge (sample/drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a single-cycle op and check the done pulse, result and flags.
  task automatic single_op(input string name, input logic [2:0] o,
                           input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                           input logic [SIZE-1:0] er, input logic ec, input logic ez);
    start = 1'b1; op = o; a_val = a; b_val = b;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b exp 1", name, done); end
    checks++;
    if (result !== er) begin errors++; $display("FAIL %s result: got %h exp %h", name, result, er); end
    checks++;
    if (carry !== ec) begin errors++; $display("FAIL %s carry: got %b exp %b", name, carry, ec); end
    checks++;
    if (zero !== ez) begin errors++; $display("FAIL %s zero: got %b exp %b", name, zero, ez); end
    step();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_drop: got %b exp 0", name, done); end
  endtask

  // Launch a multiply and wait (bounded) for done; lat = edges after accept, -1 on timeout.
  task automatic launch_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, output int lat);
    start = 1'b1; op = 3'b111; a_val = a; b_val = b;
    step();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 4 * SIZE; k++) begin
      step();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; op = 3'b000; a_val = '0; b_val = '0;
    repeat (2) step();
    checks++;
    if ({result, carry, zero, busy, done} !== '0)
      begin errors++; $display("FAIL reset_outputs: got r=%h c=%b z=%b b=%b d=%b exp all 0",
                               result, carry, zero, busy, done); end
    #4 rstn = 1'b1;
    repeat (2) step();
    checks++;
    if ({done, busy, result} !== '0)
      begin errors++; $display("FAIL reset_hold: got d=%b b=%b r=%h exp 0", done, busy, result); end
  endtask

  task automatic test_single_ops();
    single_op("add_wrap",   3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
    single_op("add_plain",  3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
    single_op("sub_borrow", 3'b001, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);
    single_op("sub_zero",   3'b001, 8'h33, 8'h33, 8'h00, 1'b0, 1'b1);
    single_op("and",        3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    single_op("or",         3'b011, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0);
    single_op("xor_zero",   3'b100, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1);
    single_op("shl",        3'b101, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0);
    single_op("shr",        3'b110, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0);
  endtask

  task automatic test_hold();
    single_op("hold_setup", 3'b000, 8'h21, 8'h01, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a_val = 8'hFF - 8'(i); b_val = 8'(i * 3 + 1); op = 3'(i);
      step();
    end
    checks++;
    if ({result, carry, zero, done} !== {8'h22, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL hold: got r=%h c=%b z=%b d=%b exp r=22 c=0 z=0 d=0",
                               result, carry, zero, done); end
  endtask

  task automatic test_mul_normal();
    int busy_cycles;
    int done_count;
    busy_cycles = 0;
    done_count  = 0;
    start = 1'b1; op = 3'b111; a_val = 8'h0C; b_val = 8'h0B;
    step();
    start = 1'b0;
    if (busy === 1'b1) busy_cycles++;
    if (done === 1'b1) done_count++;
    for (int i = 1; i < SIZE; i++) begin
      step();
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) done_count++;
      a_val = 8'(i * 37); b_val = 8'(i * 91); op = 3'(i); start = i[0];
    end
    start = 1'b0;
    checks++;
    if (busy_cycles != SIZE)
      begin errors++; $display("FAIL mul_busy_len: got %0d exp %0d", busy_cycles, SIZE); end
    step();
    checks++;
    if ({done, busy} !== 2'b10)
      begin errors++; $display("FAIL mul_done_edge: got done=%b busy=%b exp done=1 busy=0", done, busy); end
    checks++;
    if ({result, carry, zero} !== {8'h84, 1'b0, 1'b0})
      begin errors++; $display("FAIL mul_result: got r=%h c=%b z=%b exp r=84 c=0 z=0",
                               result, carry, zero); end
    if (done === 1'b1) done_count++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done === 1'b1) done_count++;
    end
    checks++;
    if (done_count != 1)
      begin errors++; $display("FAIL mul_single_done: got %0d done pulses exp 1", done_count); end
  endtask

  task automatic test_mul_overflow();
    int lat;
    launch_mul(8'h20, 8'h10, lat);
    checks++;
    if (lat != SIZE) begin errors++; $display("FAIL mul_ovf_latency: got %0d exp %0d", lat, SIZE); end
    checks++;
    if ({result, carry, zero} !== {8'h00, 1'b1, 1'b1})
      begin errors++; $display("FAIL mul_ovf_result: got r=%h c=%b z=%b exp r=00 c=1 z=1",
                               result, carry, zero); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    launch_mul(8'h03, 8'h05, lat);
    checks++;
    if (lat != SIZE || result !== 8'h0F)
      begin errors++; $display("FAIL b2b_mul: got lat=%0d r=%h exp lat=%0d r=0f", lat, result, SIZE); end
    single_op("b2b_shl", 3'b101, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_mul();
    logic seen_done;
    seen_done = 1'b0;
    start = 1'b1; op = 3'b111; a_val = 8'h0C; b_val = 8'h0B;
    step();
    start = 1'b0;
    repeat (4) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b exp 1", busy); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, carry, zero} !== '0)
      begin errors++; $display("FAIL rst_mid_outputs: got b=%b d=%b r=%h c=%b z=%b exp all 0",
                               busy, done, result, carry, zero); end
    repeat (2) step();
    #4 rstn = 1'b1;
    for (int i = 0; i < 2 * SIZE; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0 || result !== 8'h00)
      begin errors++; $display("FAIL rst_mid_quiet: got activity=%b r=%h exp 0 00", seen_done, result); end
    single_op("rst_mid_add", 3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_hold();
    test_mul_normal();
    test_mul_overflow();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
